// File: rtl/a2s_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) between two A2S
// stream channels; returned R beats are steered into the owning channel's buffer.
module a2s_rd_arbiter #(
  parameter int BURST_LEN = 16
) (
  input  logic        AXI_clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  output logic [1:0]  req_ready,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] AXI_raddr,
  output logic [3:0]  AXI_arlen,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic        AXI_rvalid,
  output logic        AXI_rready,
  input  logic        AXI_rlast
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        ptr_r, ptr_s;
  logic        owner_r, owner_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] raddr_r, raddr_s;
  logic        arvalid_r, arvalid_s;
  logic        rready_r, rready_s;
  logic [1:0]  ready_r, ready_s;
  logic [1:0]  done_r, done_s;
  logic [1:0]  err_r, err_s;
  logic        grant_s;
  logic        beat_s;
  logic        at_last_s;

  function automatic logic [1:0] ch_sel(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

  assign beat_s    = AXI_rvalid & rready_r;
  assign at_last_s = (cnt_r == LAST_BEAT);

  // Winner of the current arbitration: on a tie the channel that did not win last time.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_s = ~ptr_r;
    end else begin
      grant_s = req_valid[1];
    end
  end

  // Next-state and next-register values for the IDLE/ADDR/DATA sequence.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    cnt_s     = cnt_r;
    raddr_s   = raddr_r;
    arvalid_s = arvalid_r;
    rready_s  = rready_r;
    ready_s   = 2'b00;
    done_s    = 2'b00;
    err_s     = 2'b00;
    case (state_r)
      IDLE: begin
        if (req_valid != 2'b00) begin
          ptr_s     = grant_s;
          owner_s   = grant_s;
          raddr_s   = (grant_s ? req_addr1 : req_addr0) & 32'hFFFF_FFFC;
          arvalid_s = 1'b1;
          ready_s   = ch_sel(grant_s);
          state_s   = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (arvalid_r && AXI_arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          cnt_s     = 4'd0;
          state_s   = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (beat_s) begin
          cnt_s = cnt_r + 4'd1;
          // A full burst or an early rlast both close the burst; only a clean rlast on the final beat is error-free.
          if (at_last_s || AXI_rlast) begin
            rready_s = 1'b0;
            done_s   = ch_sel(owner_r);
            err_s    = (at_last_s && AXI_rlast) ? 2'b00 : ch_sel(owner_r);
            state_s  = IDLE;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arbitration pointer, burst bookkeeping and registered AXI/handshake outputs.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= 1'b1;
      owner_r   <= 1'b0;
      cnt_r     <= 4'd0;
      raddr_r   <= 32'd0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ready_r   <= 2'b00;
      done_r    <= 2'b00;
      err_r     <= 2'b00;
    end else begin
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      cnt_r     <= cnt_s;
      raddr_r   <= raddr_s;
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      ready_r   <= ready_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign req_ready   = ready_r;
  assign req_done    = done_r;
  assign req_err     = err_r;
  assign wr_en       = beat_s ? ch_sel(owner_r) : 2'b00;
  assign wr_addr     = cnt_r;
  assign AXI_raddr   = raddr_r;
  assign AXI_arlen   = LAST_BEAT;
  assign AXI_arvalid = arvalid_r;
  assign AXI_rready  = rready_r;

endmodule
